// File: rtl/dac_pkg.sv
// dac_pkg: definitions shared between the DAC update scheduler and the
// MCP47FEB I2C writer block, so both sides agree on encodings.
//   - sched_state_t : scheduler FSM state encoding (S_IDLE..S_GAP)
//   - DAC_VW        : DAC code width of the MCP47FEB (12 bits)
//   - MCP47FEB_*    : I2C address, volatile register map and command bits
package dac_pkg;

    localparam int DAC_VW = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } sched_state_t;

    // 7-bit I2C address with A1/A0 strapped low
    localparam logic [6:0] MCP47FEB_I2C_ADDR        = 7'h60;

    // Volatile register addresses (5-bit memory map)
    localparam logic [4:0] MCP47FEB_REG_VOL_DAC0    = 5'h00;
    localparam logic [4:0] MCP47FEB_REG_VOL_DAC1    = 5'h01;
    localparam logic [4:0] MCP47FEB_REG_VOL_VREF    = 5'h08;
    localparam logic [4:0] MCP47FEB_REG_VOL_PD      = 5'h09;
    localparam logic [4:0] MCP47FEB_REG_GAIN_STATUS = 5'h0A;

    // Command bits C1:C0 in the command byte
    localparam logic [1:0] MCP47FEB_CMD_WRITE       = 2'b00;
    localparam logic [1:0] MCP47FEB_CMD_READ        = 2'b11;

endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_arbiter_pick: combinational round-robin first-set finder.
// Returns the index of the first set bit of req at or after ptr,
// wrapping around past NCH-1 back to 0.
// Ports:
//   req   in  NCH  request vector
//   ptr   in  CW   search start index (must be < NCH)
//   grant out CW   index of the selected request (0 when none)
//   any   out 1    at least one request is set
module rr_arbiter_pick #(
    parameter int NCH = 2,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [CW-1:0]  grant,
    output logic           any
);

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!any && req[(int'(ptr) + k) % NCH]) begin
                any   = 1'b1;
                grant = CW'((int'(ptr) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler: shares one MCP47FEB I2C DAC writer between NCH
// setpoint producers. Keeps the latest value per channel (coalescing
// repeated writes), picks pending channels round-robin and runs the
// enable/busy handshake with the writer, with an idle gap between
// transactions and an acceptance timeout.
// Optional build macro DAC_SCHED_REFRESH_EN: periodically marks every
// channel pending again after REFRESH_CYCLES quiet idle cycles, so DAC
// contents are restored after an external DAC reset or brown-out.
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   wr_en          per-channel write strobe
//   wr_data        per-channel values, channel i at [i*VW +: VW]
//   clear_overrun  clears all overrun flags
//   dac_enable     request to the DAC writer
//   dac_ch_sel     channel being written
//   dac_value      code being written
//   dac_busy       writer busy (acceptance until I2C complete)
//   pending        channel holds an unsent value
//   overrun        sticky: a value was replaced before being sent
//   timeout_err    one-cycle pulse when the writer never accepted
//   idle           nothing in flight and nothing pending
module dac_update_scheduler
    import dac_pkg::*;
#(
    parameter int NCH            = 2,
    parameter int VW             = DAC_VW,
    parameter int GAP_CYCLES     = 16,
    parameter int ACCEPT_TIMEOUT = 1023,
    parameter int REFRESH_CYCLES = 1000000,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]    wr_en,
    input  logic [NCH*VW-1:0] wr_data,
    input  logic            clear_overrun,
    output logic            dac_enable,
    output logic [CW-1:0]   dac_ch_sel,
    output logic [VW-1:0]   dac_value,
    input  logic            dac_busy,
    output logic [NCH-1:0]  pending,
    output logic [NCH-1:0]  overrun,
    output logic            timeout_err,
    output logic            idle
);

    // One counter serves both the accept timer and the gap timer.
    localparam int CNT_MAX = (ACCEPT_TIMEOUT > GAP_CYCLES) ? ACCEPT_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    sched_state_t            state_q, state_d;
    logic [NCH-1:0]          pending_q, pending_d;
    logic [NCH-1:0]          overrun_q, overrun_d;
    logic [NCH-1:0][VW-1:0]  shadow_q, shadow_d;
    logic [CW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]           sel_q, sel_d;
    logic [VW-1:0]           value_q, value_d;
    logic                    enable_q, enable_d;
    logic                    tout_q, tout_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [CW-1:0]           grant;
    logic                    any_req;
    logic                    issue;
    logic                    requeue;

`ifdef DAC_SCHED_REFRESH_EN
    localparam int RF_W = $clog2(REFRESH_CYCLES + 1);
    logic [RF_W-1:0]         refresh_q, refresh_d;
`endif

    rr_arbiter_pick #(
        .NCH (NCH)
    ) u_pick (
        .req   (pending_q),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .any   (any_req)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        shadow_d  = shadow_q;
        rr_ptr_d  = rr_ptr_q;
        sel_d     = sel_q;
        value_d   = value_q;
        enable_d  = enable_q;
        tout_d    = 1'b0;
        cnt_d     = cnt_q;
        issue     = 1'b0;
        requeue   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (any_req) begin
                    issue    = 1'b1;
                    sel_d    = grant;
                    value_d  = shadow_q[grant];
                    enable_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                // Acceptance wins over a timeout landing in the same cycle.
                if (dac_busy) begin
                    enable_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_WAIT;
                end else if (cnt_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    enable_d = 1'b0;
                    requeue  = 1'b1;
                    tout_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_GAP;
                end
            end
            S_WAIT: begin
                if (!dac_busy) begin
                    rr_ptr_d = (int'(sel_q) == NCH - 1) ? '0 : sel_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                // GAP_CYCLES of 0 still spends one cycle here.
                if ((int'(cnt_q) + 1) >= GAP_CYCLES) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_overrun) begin
            overrun_d = '0;
        end

        // Order matters: a write on the channel being issued re-arms pending
        // after the issue cleared it, so the newer value goes out later.
        for (int i = 0; i < NCH; i++) begin
            if (issue && int'(grant) == i) begin
                pending_d[i] = 1'b0;
            end
            if (requeue && int'(sel_q) == i) begin
                pending_d[i] = 1'b1;
            end
            if (wr_en[i]) begin
                shadow_d[i]  = wr_data[i*VW +: VW];
                pending_d[i] = 1'b1;
                if (pending_q[i] && !(issue && int'(grant) == i)) begin
                    overrun_d[i] = 1'b1;
                end
            end
        end

`ifdef DAC_SCHED_REFRESH_EN
        refresh_d = refresh_q;
        if (issue) begin
            refresh_d = '0;
        end else if (state_q == S_IDLE && pending_q == '0) begin
            if (refresh_q == RF_W'(REFRESH_CYCLES - 1)) begin
                refresh_d = '0;
                pending_d = '1;
            end else begin
                refresh_d = refresh_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            shadow_q  <= '0;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            value_q   <= '0;
            enable_q  <= 1'b0;
            tout_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= sel_d;
            value_q   <= value_d;
            enable_q  <= enable_d;
            tout_q    <= tout_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef DAC_SCHED_REFRESH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`endif

    assign dac_enable  = enable_q;
    assign dac_ch_sel  = sel_q;
    assign dac_value   = value_q;
    assign pending     = pending_q;
    assign overrun     = overrun_q;
    assign timeout_err = tout_q;
    assign idle        = (state_q == S_IDLE) && (pending_q == '0);

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler (NCH=2, VW=12, default gap and
// timeout). A simple DAC writer model raises busy half a cycle after it
// sees enable and holds it for 50 cycles, logging each accepted write.
module tb_dac_update_scheduler;

    localparam int NCH  = 2;
    localparam int VW   = 12;
    localparam int GAP  = 16;
    localparam int ATO  = 1023;
    localparam int BUSY_LEN = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    wr_en = '0;
    logic [NCH*VW-1:0] wr_data = '0;
    logic              clear_overrun = 1'b0;
    logic              dac_enable;
    logic [0:0]        dac_ch_sel;
    logic [VW-1:0]     dac_value;
    logic              dac_busy = 1'b0;
    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    overrun;
    logic              timeout_err;
    logic              idle;

    int n_tests = 0;
    int n_fail  = 0;

    int busy_mode = 1;
    int busy_cnt  = 0;
    int tout_cnt  = 0;
    int log_ch  [256];
    int log_val [256];
    int log_n   = 0;

    dac_update_scheduler #(
        .NCH            (NCH),
        .VW             (VW),
        .GAP_CYCLES     (GAP),
        .ACCEPT_TIMEOUT (ATO),
        .REFRESH_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .clear_overrun (clear_overrun),
        .dac_enable    (dac_enable),
        .dac_ch_sel    (dac_ch_sel),
        .dac_value     (dac_value),
        .dac_busy      (dac_busy),
        .pending       (pending),
        .overrun       (overrun),
        .timeout_err   (timeout_err),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and run the writer model.
    task automatic step();
        @(negedge clk);
        if (timeout_err) tout_cnt++;
        if (busy_mode != 0) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) dac_busy = 1'b0;
            end else if (dac_enable && !dac_busy) begin
                dac_busy = 1'b1;
                busy_cnt = BUSY_LEN;
                log_ch[log_n]  = int'(dac_ch_sel);
                log_val[log_n] = int'(dac_value);
                log_n++;
            end
        end
    endtask

    task automatic put(input logic [1:0] en, input logic [11:0] v1, input logic [11:0] v0);
        wr_en   = en;
        wr_data = {v1, v0};
        step();
        wr_en   = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!idle && n < 400);
        check(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        int n0;
        int n;

        // Reset state
        step();
        step();
        check("rst_enable",  32'(dac_enable),  32'd0);
        check("rst_ch_sel",  32'(dac_ch_sel),  32'd0);
        check("rst_value",   32'(dac_value),   32'd0);
        check("rst_pending", 32'(pending),     32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_idle",    32'(idle),        32'd1);
        rst = 1'b0;
        step();

        // Single write on ch1
        put(2'b10, 12'hABC, 12'h000);
        check("t1_pending_cap", 32'(pending),    32'h2);
        check("t1_enable_cap",  32'(dac_enable), 32'd0);
        check("t1_idle_cap",    32'(idle),       32'd0);
        step();
        check("t1_enable_sel",  32'(dac_enable), 32'd1);
        check("t1_ch_sel",      32'(dac_ch_sel), 32'd1);
        check("t1_value",       32'(dac_value),  32'hABC);
        check("t1_pending_sel", 32'(pending),    32'h0);
        step();
        check("t1_enable_drop", 32'(dac_enable), 32'd0);
        check("t1_value_hold",  32'(dac_value),  32'hABC);
        for (int k = 0; k < 100 && dac_busy; k++) step();
        n = 0;
        while (!idle && n < 100) begin
            step();
            n++;
        end
        check("t1_gap_len", 32'(n), 32'(GAP + 1));

        // Both channels together, twice: round robin restarts at ch0
        n0 = log_n;
        put(2'b11, 12'h222, 12'h111);
        wait_idle("t2_idle_a");
        check("t2_count_a", 32'(log_n - n0),    32'd2);
        check("t2_ch_a0",   32'(log_ch[n0]),    32'd0);
        check("t2_val_a0",  32'(log_val[n0]),   32'h111);
        check("t2_ch_a1",   32'(log_ch[n0+1]),  32'd1);
        check("t2_val_a1",  32'(log_val[n0+1]), 32'h222);
        n0 = log_n;
        put(2'b11, 12'h444, 12'h333);
        wait_idle("t2_idle_b");
        check("t2_ch_b0",   32'(log_ch[n0]),    32'd0);
        check("t2_val_b0",  32'(log_val[n0]),   32'h333);
        check("t2_ch_b1",   32'(log_ch[n0+1]),  32'd1);
        check("t2_val_b1",  32'(log_val[n0+1]), 32'h444);

        // Coalescing while the writer is busy on ch1
        n0 = log_n;
        put(2'b10, 12'h555, 12'h000);
        step();
        put(2'b01, 12'h000, 12'h100);
        check("t3_no_overrun_first", 32'(overrun), 32'h0);
        put(2'b01, 12'h000, 12'h200);
        put(2'b01, 12'h000, 12'h300);
        check("t3_overrun_set", 32'(overrun), 32'h1);
        wait_idle("t3_idle");
        check("t3_count",   32'(log_n - n0),    32'd2);
        check("t3_ch0",     32'(log_ch[n0]),    32'd1);
        check("t3_val0",    32'(log_val[n0]),   32'h555);
        check("t3_ch1",     32'(log_ch[n0+1]),  32'd0);
        check("t3_val1",    32'(log_val[n0+1]), 32'h300);
        check("t3_overrun_sticky", 32'(overrun), 32'h1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 32'h0);

        // Write on the channel being selected in the same cycle
        n0 = log_n;
        put(2'b01, 12'h000, 12'hAAA);
        put(2'b01, 12'h000, 12'hBBB);
        check("tc_value",   32'(dac_value), 32'hAAA);
        check("tc_pending", 32'(pending),   32'h1);
        check("tc_overrun", 32'(overrun),   32'h0);
        wait_idle("tc_idle");
        check("tc_count",   32'(log_n - n0),    32'd2);
        check("tc_val1",    32'(log_val[n0+1]), 32'hBBB);

        // Writer never accepts: timeout, then retry after the gap
        busy_mode = 0;
        tout_cnt  = 0;
        n0 = log_n;
        put(2'b01, 12'h000, 12'h777);
        step();
        check("t4_enable", 32'(dac_enable), 32'd1);
        n = 0;
        while (dac_enable && n < 1100) begin
            step();
            n++;
        end
        check("t4_enable_len", 32'(n),           32'(ATO));
        check("t4_tout_pulse", 32'(timeout_err), 32'd1);
        check("t4_requeue",    32'(pending),     32'h1);
        busy_mode = 1;
        step();
        check("t4_tout_one",   32'(timeout_err), 32'd0);
        wait_idle("t4_idle");
        check("t4_retry_ch",   32'(log_ch[n0]),  32'd0);
        check("t4_retry_val",  32'(log_val[n0]), 32'h777);
        check("t4_tout_count", 32'(tout_cnt),    32'd1);

        // Asynchronous reset while waiting on busy
        put(2'b10, 12'h09A, 12'h000);
        step();
        step();
        put(2'b01, 12'h000, 12'h0F0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_enable",  32'(dac_enable), 32'd0);
        check("t5_ch_sel",  32'(dac_ch_sel), 32'd0);
        check("t5_value",   32'(dac_value),  32'd0);
        check("t5_pending", 32'(pending),    32'd0);
        check("t5_idle",    32'(idle),       32'd1);
        dac_busy = 1'b0;
        busy_cnt = 0;
        step();
        rst = 1'b0;
        n0 = log_n;
        put(2'b01, 12'h000, 12'h5A5);
        wait_idle("t5_idle_after");
        check("t5_count", 32'(log_n - n0),  32'd1);
        check("t5_ch",    32'(log_ch[n0]),  32'd0);
        check("t5_val",   32'(log_val[n0]), 32'h5A5);

`ifdef DAC_SCHED_REFRESH_EN
        // Quiet idle period triggers a rewrite of every channel
        n0 = log_n;
        n = 0;
        while (log_n < n0 + 2 && n < 400) begin
            step();
            n++;
        end
        check("t6_count", 32'(log_n - n0),    32'd2);
        check("t6_ch0",   32'(log_ch[n0]),    32'd1);
        check("t6_val0",  32'(log_val[n0]),   32'h000);
        check("t6_ch1",   32'(log_ch[n0+1]),  32'd0);
        check("t6_val1",  32'(log_val[n0+1]), 32'h5A5);
        check("t6_overrun", 32'(overrun), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Shares one MCP47FEB I2C DAC writer between NCH channel requesters.
- Latches the latest value per channel and coalesces repeated writes.
- Picks pending channels round-robin and runs the downstream enable/busy handshake for each one.
- Sits between control logic (setpoint producers) and the DAC writer block.

Parameters:
- NCH, 2, number of DAC channels/requesters (1..8)
- VW, 12, DAC code width
- GAP_CYCLES, 16, idle clk cycles enforced between consecutive transactions
- ACCEPT_TIMEOUT, 1023, max cycles waiting for dac_busy to rise after enable
- REFRESH_CYCLES, 1000000, periodic refresh interval (only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  NCH  per-channel write strobe, one cycle per new value
- wr_data  in  NCH*VW  per-channel value; channel i uses bits [i*VW +: VW]
- clear_overrun  in  1  clears all overrun flags
- dac_enable  out  1  request to DAC writer
- dac_ch_sel  out  CW  channel index being written; CW = max(1, clog2(NCH))
- dac_value  out  VW  code being written
- dac_busy  in  1  DAC writer busy (high from acceptance until I2C complete)
- pending  out  NCH  channel has an unsent value
- overrun  out  NCH  sticky: value overwritten before being sent
- timeout_err  out  1  one-cycle pulse on accept timeout
- idle  out  1  state==S_IDLE and pending==0

Behaviour:
- Reset state: all registers 0 and state S_IDLE. Outputs: dac_enable=0, dac_ch_sel=0, dac_value=0, pending=0, overrun=0, timeout_err=0, idle=1. Round-robin pointer is 0 and shadow values are 0. Reset mid-transaction drops enable immediately; no retry is issued.
- Capture: on wr_en[i], shadow[i]<=wr_data slice and pending[i]<=1. If pending[i] was already 1 and channel i is not being issued in that cycle, overrun[i]<=1.
- clear_overrun clears overrun. A same-cycle overrun event wins over the clear.
- States: S_IDLE, S_ISSUE, S_WAIT, S_GAP.
- S_IDLE:
  - If any pending bit is set, select the first pending channel at or after rr_ptr, wrapping around.
  - Register dac_ch_sel and dac_value from shadow, clear pending[sel], and set dac_enable=1 from the next cycle.
  - Go to S_ISSUE.
- Write vs. issue collision: a wr_en on the channel being selected in that same cycle sets pending again, so the new value is sent later. It does not set overrun.
- S_ISSUE:
  - dac_enable held at 1 and a timer counts up.
  - On dac_busy==1: dac_enable<=0 and go to S_WAIT.
  - When the timer reaches ACCEPT_TIMEOUT: dac_enable<=0, re-set pending[sel] (keeping any newer shadow), pulse timeout_err, go to S_GAP.
- S_WAIT: on dac_busy==0, set rr_ptr<=sel+1 (wraps to 0 at NCH) and go to S_GAP.
- S_GAP: count GAP_CYCLES cycles, then go to S_IDLE. GAP_CYCLES=0 means one cycle straight through.
- dac_ch_sel and dac_value stay stable from issue until the next issue.
- Latency: wr_en on an idle block gives dac_enable=1 two cycles later (capture, select).
- NCH=1: rr_ptr is constant 0.

Optional Feature:
- Macro DAC_SCHED_REFRESH_EN.
- With the macro: a counter increments in S_IDLE while pending==0. When it reaches REFRESH_CYCLES, all pending bits are set (no overrun) and every channel is rewritten. The counter clears on any issue. This recovers DAC state after an external DAC reset/brown-out.
- Without the macro: no counter logic, and the REFRESH_CYCLES parameter is unused.

Decomposition:
- Shared package dac_pkg:
  - state encoding constants S_IDLE..S_GAP
  - DAC_VW=12
  - MCP47FEB address/register constants, so the writer block and this block agree
- One sub-module, rr_arbiter_pick: combinational NCH-bit round-robin first-set finder (req, ptr -> grant index, any).

Test Plan:
- Single write ch1=0xABC: dac_enable rises 2 cycles later with ch_sel=1, value=0xABC. Model busy high 1 cycle after enable for 50 cycles. Expect enable low after busy high, then GAP_CYCLES idle, then idle=1.
- Both channels written in the same cycle (0x111, 0x222): ch0 issued first, then ch1 after the gap. Next simultaneous pair starts from ch0 again because rr_ptr wrapped.
- ch0 written 0x100, then 0x200, then 0x300 while the DAC is busy on ch1: only 0x300 is sent on ch0; overrun[0]=1. clear_overrun -> 0.
- Busy held low forever: after ACCEPT_TIMEOUT cycles timeout_err pulses once and enable drops. pending[sel] is re-set and the channel is retried after the gap.
- rst asserted in S_WAIT: all outputs return to reset values asynchronously and pending=0. A new write after reset issues normally.
- With DAC_SCHED_REFRESH_EN and REFRESH_CYCLES=100: no writes for 100 idle cycles, then both channels are rewritten with their last shadow values.
